// File: rtl/activity_pulse_gen.sv
// Programmable step-pulse source: emits `rate` evenly spaced pulses per one-second
// window for `duration` seconds (or until stopped), using a rate accumulator.
module activity_pulse_gen #(
    parameter int CLK_PER_SEC = 1000,
    parameter int PULSE_WIDTH = 2,
    parameter int RATE_W      = 9,
    parameter int DUR_W       = 8,
    parameter int ACC_W       = 28,
    parameter int MAX_RATE    = CLK_PER_SEC / (PULSE_WIDTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate,
    input  logic [DUR_W-1:0]  duration,
    output logic              Pulse,
    output logic              busy,
    output logic              done,
    output logic              sec_tick,
    output logic [15:0]       pulse_total,
    output logic              clamped
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam int WID_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [ACC_W-1:0] LP_CPS      = ACC_W'(CLK_PER_SEC);
    localparam logic [ACC_W-1:0] LP_SEC_LAST = ACC_W'(CLK_PER_SEC - 1);
    localparam logic [ACC_W-1:0] LP_MAX_RATE = ACC_W'(MAX_RATE);
    localparam logic [WID_W-1:0] LP_WID_LAST = WID_W'(PULSE_WIDTH - 1);

    state_t            r_state;
    logic [RATE_W-1:0] r_rateQ;
    logic [DUR_W-1:0]  r_secsLeft;
    logic              r_untilStop;
    logic              r_finished;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_secCnt;
    logic [WID_W-1:0]  r_widthCnt;
    logic              r_pulse;
    logic              r_done;
    logic [15:0]       r_total;
    logic              r_clamped;

    logic [ACC_W-1:0]  w_rateExt;
    logic [ACC_W-1:0]  w_rateQExt;
    logic [ACC_W-1:0]  w_accSum;
    logic              w_fire;
    logic              w_lastCycle;

    assign w_rateExt   = ACC_W'(rate);
    assign w_rateQExt  = ACC_W'(r_rateQ);
    assign w_accSum    = r_acc + w_rateQExt;
    assign w_fire      = (r_state == S_RUN) && (w_accSum >= LP_CPS);
    assign w_lastCycle = (r_state == S_RUN) && (r_secCnt == LP_SEC_LAST);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_rateQ     <= '0;
            r_secsLeft  <= '0;
            r_untilStop <= 1'b0;
            r_finished  <= 1'b0;
            r_acc       <= '0;
            r_secCnt    <= '0;
            r_widthCnt  <= '0;
            r_pulse     <= 1'b0;
            r_done      <= 1'b0;
            r_total     <= '0;
            r_clamped   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A fire coinciding with stop is dropped; otherwise a started pulse always runs full width.
            if (w_fire && !stop) begin
                r_pulse    <= 1'b1;
                r_widthCnt <= LP_WID_LAST;
                if (r_total != 16'hFFFF) begin
                    r_total <= r_total + 16'd1;
                end
            end else if (r_pulse) begin
                if (r_widthCnt == '0) begin
                    r_pulse <= 1'b0;
                end else begin
                    r_widthCnt <= r_widthCnt - WID_W'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        if (w_rateExt > LP_MAX_RATE) begin
                            r_rateQ   <= RATE_W'(MAX_RATE);
                            r_clamped <= 1'b1;
                        end else begin
                            r_rateQ   <= rate;
                            r_clamped <= 1'b0;
                        end
                        r_secsLeft  <= duration;
                        r_untilStop <= (duration == '0);
                        r_finished  <= 1'b0;
                        r_total     <= '0;
                        r_secCnt    <= '0;
                        r_acc       <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state    <= S_DRAIN;
                        r_finished <= 1'b0;
                    end else begin
                        // The accumulator returns to exactly zero at each window end.
                        r_acc <= w_fire ? (w_accSum - LP_CPS) : w_accSum;
                        if (w_lastCycle) begin
                            r_secCnt <= '0;
                            if (!r_untilStop) begin
                                r_secsLeft <= r_secsLeft - DUR_W'(1);
                                if (r_secsLeft == DUR_W'(1)) begin
                                    r_state    <= S_DRAIN;
                                    r_finished <= 1'b1;
                                end
                            end
                        end else begin
                            r_secCnt <= r_secCnt + ACC_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_pulse) begin
                        r_state <= S_IDLE;
                        r_done  <= r_finished;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Pulse       = r_pulse;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign sec_tick    = w_lastCycle;
    assign pulse_total = r_total;
    assign clamped     = r_clamped;

endmodule

// File: tb/tb_activity_pulse_gen.sv
// Scoreboard bench for activity_pulse_gen: expected pulse/tick/done times come from
// the closed-form per-window pulse schedule, and a monitor matches them as they appear.
module tb_activity_pulse_gen;

    localparam int CPS  = 1000;
    localparam int PW   = 2;
    localparam int MAXR = CPS / (PW + 1);

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        stop;
    logic [8:0]  rate;
    logic [7:0]  duration;
    logic        Pulse;
    logic        busy;
    logic        done;
    logic        sec_tick;
    logic [15:0] pulse_total;
    logic        clamped;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit monOn = 1'b0;
    bit prevPulse = 1'b0;
    int hiLen = 0;

    int riseQ[$];
    int tickQ[$];
    int doneQ[$];
    int totQ[$];

    activity_pulse_gen #(
        .CLK_PER_SEC(CPS),
        .PULSE_WIDTH(PW),
        .RATE_W(9),
        .DUR_W(8),
        .ACC_W(28)
    ) dut (
        .CLK(clk),
        .RESET(rstN),
        .start(start),
        .stop(stop),
        .rate(rate),
        .duration(duration),
        .Pulse(Pulse),
        .busy(busy),
        .done(done),
        .sec_tick(sec_tick),
        .pulse_total(pulse_total),
        .clamped(clamped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Pulse k (1-based) of a window fires in the first cycle c where (c+1)*rate >= k*CPS,
    // and becomes visible one cycle later.
    task automatic pushModel(input int r, input int d, input int t0, input int stopT, output int total);
        int rq;
        int nw;
        int lastRise;
        int c;
        int rise;
        int tick;
        int doneT;
        rq = (r > MAXR) ? MAXR : r;
        nw = (stopT >= 0) ? (stopT / CPS + 1) : d;
        total = 0;
        lastRise = -100;
        for (int w = 0; w < nw; w++) begin
            for (int k = 1; k <= rq; k++) begin
                c = (k * CPS + rq - 1) / rq - 1;
                rise = w * CPS + c + 1;
                if (stopT < 0 || rise <= stopT) begin
                    riseQ.push_back(t0 + rise);
                    total++;
                    lastRise = rise;
                end
            end
            tick = w * CPS + CPS - 1;
            if (stopT < 0 || tick <= stopT) tickQ.push_back(t0 + tick);
        end
        if (total > 65535) total = 65535;
        if (stopT < 0) begin
            doneT = d * CPS + 1;
            if (lastRise + PW + 1 > doneT) doneT = lastRise + PW + 1;
            doneQ.push_back(t0 + doneT);
            totQ.push_back(total);
        end
    endtask

    task automatic applyStimulus(input int r, input int d, output int t0);
        @(negedge clk);
        rate = 9'(r);
        duration = 8'(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rate = 9'($urandom);
        duration = 8'($urandom);
        t0 = cyc;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput({name, " busy timeout"}, int'(busy), 0);
        repeat (2) @(negedge clk);
        checkOutput({name, " rises left"}, riseQ.size(), 0);
        checkOutput({name, " ticks left"}, tickQ.size(), 0);
        checkOutput({name, " dones left"}, doneQ.size(), 0);
        riseQ.delete();
        tickQ.delete();
        doneQ.delete();
        totQ.delete();
    endtask

    // Monitor: matches observed rises, ticks and done strobes against the scoreboard.
    always @(negedge clk) begin
        if (monOn) begin
            if (Pulse && !prevPulse) begin
                if (riseQ.size() == 0) checkOutput("unexpected rise", cyc, -1);
                else checkOutput("rise time", cyc, riseQ.pop_front());
            end
            if (!Pulse && prevPulse) checkOutput("pulse width", hiLen, PW);
            if (sec_tick) begin
                if (tickQ.size() == 0) checkOutput("unexpected sec_tick", cyc, -1);
                else checkOutput("sec_tick time", cyc, tickQ.pop_front());
            end
            if (done) begin
                if (doneQ.size() == 0) checkOutput("unexpected done", cyc, -1);
                else begin
                    checkOutput("done time", cyc, doneQ.pop_front());
                    checkOutput("pulse_total at done", int'(pulse_total), totQ.pop_front());
                end
            end
        end
        if (Pulse) hiLen = prevPulse ? hiLen + 1 : 1;
        prevPulse = Pulse;
    end

    initial begin
        int t0;
        int tot;
        int r;
        int d;
        bit seen;
        rstN = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        rate = '0;
        duration = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset Pulse", int'(Pulse), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset sec_tick", int'(sec_tick), 0);
        checkOutput("reset pulse_total", int'(pulse_total), 0);
        checkOutput("reset clamped", int'(clamped), 0);
        rstN = 1'b1;
        monOn = 1'b1;
        @(negedge clk);

        // rate 64 for 2 s, with a second start mid-run that must be ignored
        applyStimulus(64, 2, t0);
        pushModel(64, 2, t0, -1, tot);
        while (cyc < t0 + 500) @(negedge clk);
        rate = 9'd10;
        duration = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle("rate64");
        checkOutput("rate64 total", int'(pulse_total), 128);
        checkOutput("rate64 clamped", int'(clamped), 0);

        // rate 0: seconds still counted, no pulses
        applyStimulus(0, 3, t0);
        pushModel(0, 3, t0, -1, tot);
        waitIdle("rate0");
        checkOutput("rate0 total", int'(pulse_total), 0);

        // over-range rate clamps to the maximum
        applyStimulus(500, 1, t0);
        pushModel(500, 1, t0, -1, tot);
        waitIdle("clamp");
        checkOutput("clamp total", int'(pulse_total), 333);
        checkOutput("clamp flag", int'(clamped), 1);

        // open-ended run stopped while a pulse is high
        applyStimulus(100, 0, t0);
        pushModel(100, 0, t0, 2500, tot);
        while (cyc < t0 + 2500) @(negedge clk);
        checkOutput("Pulse high at stop", int'(Pulse), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        waitIdle("stop");
        checkOutput("stop total", int'(pulse_total), tot);
        checkOutput("stop total spec", int'(pulse_total), 250);

        // reset asserted mid-pulse
        monOn = 1'b0;
        applyStimulus(500, 2, t0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (Pulse) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("pulse seen before reset", int'(seen), 1);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("midrun reset Pulse", int'(Pulse), 0);
        checkOutput("midrun reset busy", int'(busy), 0);
        checkOutput("midrun reset total", int'(pulse_total), 0);
        checkOutput("midrun reset clamped", int'(clamped), 0);
        @(negedge clk);
        checkOutput("midrun reset done", int'(done), 0);
        monOn = 1'b1;

        // randomized finite runs
        for (int n = 0; n < 7; n++) begin
            r = $urandom_range(0, 400);
            d = $urandom_range(1, 2);
            applyStimulus(r, d, t0);
            pushModel(r, d, t0, -1, tot);
            waitIdle("random");
            checkOutput("random total", int'(pulse_total), tot);
            checkOutput("random clamped", int'(clamped), (r > MAXR) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/activity_pulse_gen.md
Name: activity_pulse_gen

Overview:
- Stimulus/transmitter counterpart to the high-activity pulse counter: generates step pulses on `Pulse` at a programmed rate (pulses per second) for a programmed number of seconds.
- Spaces pulses evenly within each one-second window using a rate accumulator, with exact pulse count per second.
- Used as an on-chip pulse source for sensor emulation and self-test, driving the counter's `Pulse` input directly.

Parameters:
- CLK_PER_SEC, 1000: CLK cycles per one-second window (simulation scaling; 100000000 on hardware).
- PULSE_WIDTH, 2: cycles `Pulse` stays high per pulse, ≥1.
- RATE_W, 9: width of the rate input.
- DUR_W, 8: width of the duration input.
- ACC_W, 28: width of the second counter and accumulator. Requires 2^ACC_W > CLK_PER_SEC + 2^RATE_W.
- MAX_RATE, CLK_PER_SEC/(PULSE_WIDTH+1): highest legal rate; 333 at defaults.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset (RESET=0 clears all state on the next rising CLK edge).
- start  in  1  one-cycle strobe; latches rate/duration and begins a run; honoured only in IDLE.
- stop  in  1  one-cycle strobe; aborts a run.
- rate  in  RATE_W  pulses per second requested.
- duration  in  DUR_W  run length in seconds; 0 = run until stop.
- Pulse  out  1  generated step pulse, registered.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle strobe when a finite run completes normally.
- sec_tick  out  1  one-cycle strobe at the last cycle of each completed second window.
- pulse_total  out  16  rising edges emitted in the current/last run; saturates at 65535.
- clamped  out  1  latched high when the requested rate > MAX_RATE.

Behaviour:
- Reset values: Pulse=0, busy=0, done=0, sec_tick=0, pulse_total=0, clamped=0. Internal state: IDLE, sec_cnt=0, acc=0.
- States: IDLE, RUN, DRAIN.

IDLE:
- start → latch rate_q = min(rate, MAX_RATE), clamped = (rate > MAX_RATE), secs_left = duration.
- Clear pulse_total, sec_cnt and acc; go to RUN on the next cycle.
- stop in IDLE is ignored.

RUN, each cycle:
- Fire condition: acc + rate_q ≥ CLK_PER_SEC.
- On fire: acc ← acc + rate_q − CLK_PER_SEC. Otherwise: acc ← acc + rate_q.
- On fire, Pulse rises on the next edge and stays high exactly PULSE_WIDTH cycles; pulse_total increments when Pulse rises.
- sec_cnt counts 0..CLK_PER_SEC−1.
- At sec_cnt = CLK_PER_SEC−1:
  - sec_tick=1 and sec_cnt wraps to 0.
  - acc is exact 0 at this point, so every window emits exactly rate_q fires.
  - If duration ≠ 0: decrement secs_left; reaching 0 → DRAIN with finished=1.
- First fire is at window cycle ceil(CLK_PER_SEC/rate_q)−1. The last fire of a window is at cycle CLK_PER_SEC−1, and its pulse tail spans into the next window.
- The rate clamp guarantees fire spacing ≥ PULSE_WIDTH+1, so pulses never merge.
- rate_q=0: no fires, seconds still counted.
- stop in RUN → DRAIN with finished=0. A fire occurring in the same cycle as stop is suppressed.

DRAIN:
- No new fires. Any in-progress pulse completes its full PULSE_WIDTH.
- When Pulse is low → IDLE. done=1 for that one cycle only if finished=1.
- stop in DRAIN is ignored.

Other rules:
- start while busy is ignored; latched rate/duration are unchanged.
- start and stop together in IDLE: start wins.
- pulse_total and clamped hold their values in IDLE until the next start.
- RESET low mid-pulse or mid-run: Pulse=0 on the next edge, no done, all state cleared.

Test Plan:
- rate=64, duration=2, start → first Pulse rise at cycle 16 after RUN entry; exactly 64 rises per 1000-cycle window; pulse_total=128; done one cycle after the final pulse falls; 2 sec_ticks.
- rate=0, duration=3 → Pulse stays 0; 3 sec_ticks 1000 cycles apart; done after the third; pulse_total=0.
- rate=500, duration=1 → clamped=1; 333 rises; each pulse high exactly 2 cycles with ≥1 low cycle between; pulse_total=333.
- rate=100, duration=0, stop at cycle 2500 while Pulse is high → pulse completes its 2 cycles; busy drops; done never asserts; pulse_total=250.
- RESET=0 for one cycle mid-run while Pulse is high → next cycle Pulse=0, busy=0, pulse_total=0, clamped=0; a start afterwards behaves as a fresh run.
- start pulsed again during RUN with rate=10 → ignored; rate stays 64 (128 pulses over 2 s).
